// File: rtl/serial_deser_pkg.sv
// Shared constants for the serial deserializer: FSM encodings and default width.
package serial_deser_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // FSM encodings
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/serial_deser_shift_reg.sv
// Enable-gated WIDTH-bit left shifter with asynchronous active-low reset.
// The new bit enters at bit 0, so after WIDTH shifts the first bit sits in the MSB.
module shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             in_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: shift left by one and insert the serial bit when enabled
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = (q_q << 1) | WIDTH'(in_i);
    end
  end

  // Shift register flops
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_deser.sv
// Bit-serial to parallel deserializer. A start bit (1) opens a frame, WIDTH data
// bits follow MSB-first, and the word is offered on a valid/ready output register.
//
// Output handshake: a word transfers on any cycle where out_valid_o=1 and
// out_ready_i=1. While out_valid_o=1 and out_ready_i=0, out_o and out_valid_o
// hold steady. out_ready_i has no effect while out_valid_o=0. A frame that
// completes while the output holds an unaccepted word is dropped and flags
// overrun_o; if the word is accepted on that same cycle, the new word loads.
// busy_o mirrors the FSM state (1 = SHIFT) and doubles as its debug view.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             in_i,
  input  logic             out_ready_i,
  input  logic             clr_ovr_i,
  output logic [WIDTH-1:0] out_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic             overrun_o
);

  // Counter width is derived from WIDTH and is not meant to be overridden.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shreg;
  logic             shift_en;
  logic             frame_end;
  logic [WIDTH-1:0] word;

  // Data bits only shift while a frame is open; start bits never enter the register.
  assign shift_en  = en_i && (state_q == ST_SHIFT);
  assign frame_end = shift_en && (cnt_q == CNT_LAST);
  // The final bit bypasses the shifter so the word is ready on the same edge.
  assign word      = (shreg << 1) | WIDTH'(in_i);

  shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (shift_en),
    .in_i    (in_i),
    .q_o     (shreg)
  );

  // FSM and bit counter next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i && in_i) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (en_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register, valid flag and sticky overrun next-state
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_ovr_i) begin
      ovr_d = 1'b0;
    end
    if (frame_end) begin
      if (!valid_q || out_ready_i) begin
        out_d   = word;
        valid_d = 1'b1;
      end else begin
        // set wins over a simultaneous clear
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State, counter and output flops
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = valid_q;
  assign busy_o      = (state_q == ST_SHIFT);
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser (WIDTH=16): framing, gaps, overrun,
// same-cycle accept-and-load, idle zeros and mid-frame async reset.
module tb_serial_deser;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         din;
  logic         ready;
  logic         clr_ovr;
  logic [W-1:0] dout;
  logic         valid;
  logic         busy;
  logic         ovr;

  int n_checks;
  int n_errors;
  int busy_low_cnt;
  int busy_high_cnt;
  int valid_high_cnt;

  serial_deser #(
    .WIDTH (W)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .in_i        (din),
    .out_ready_i (ready),
    .clr_ovr_i   (clr_ovr),
    .out_o       (dout),
    .out_valid_o (valid),
    .busy_o      (busy),
    .overrun_o   (ovr)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one cycle; inputs change 1ns after the edge, outputs sampled there too
  task automatic step(input logic b, input logic e);
    en  = e;
    din = b;
    @(posedge clk);
    #1;
  endtask

  // start bit plus 16 data bits with en=1 every cycle; ready_last drives
  // out_ready_i only during the final-bit cycle
  task automatic send_frame(input logic [W-1:0] w, input logic ready_last);
    step(1'b1, 1'b1);
    for (int i = W - 1; i >= 1; i--) step(w[i], 1'b1);
    ready = ready_last;
    step(w[0], 1'b1);
    ready = 1'b0;
    en    = 1'b0;
  endtask

  task automatic consume();
    ready = 1'b1;
    step(1'b0, 1'b0);
    ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; en = 1'b0; din = 1'b0; ready = 1'b0; clr_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out",   dout,  16'h0000);
    check("rst_valid", valid, 1'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst_ovr",   ovr,   1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    // 1: continuous strobe, A5C3
    w = 16'hA5C3;
    step(1'b1, 1'b1);
    check("t1_busy_after_start", busy, 1'b1);
    for (int i = W - 1; i >= 1; i--) step(w[i], 1'b1);
    check("t1_valid_before_last", valid, 1'b0);
    check("t1_busy_before_last",  busy,  1'b1);
    step(w[0], 1'b1);
    en = 1'b0;
    check("t1_valid", valid, 1'b1);
    check("t1_out",   dout,  16'hA5C3);
    check("t1_busy",  busy,  1'b0);
    step(1'b0, 1'b0);
    check("t1_hold_valid", valid, 1'b1);
    consume();
    check("t1_consumed_valid", valid, 1'b0);
    check("t1_consumed_out",   dout,  16'hA5C3);

    // 2: toggling strobe, with 3-cycle gaps after bits 5 and 11
    busy_low_cnt = 0;
    step(1'b1, 1'b1);
    for (int i = W - 1; i >= 0; i--) begin
      step(w[i], 1'b1);
      if (i != 0) begin
        if (!busy) busy_low_cnt++;
        repeat ((i == 10 || i == 4) ? 3 : 1) begin
          step(1'($urandom_range(0, 1)), 1'b0);
          if (!busy) busy_low_cnt++;
        end
      end
    end
    en = 1'b0;
    check("t2_busy_low_in_frame", busy_low_cnt, 0);
    check("t2_valid", valid, 1'b1);
    check("t2_out",   dout,  16'hA5C3);
    check("t2_busy",  busy,  1'b0);
    consume();

    // 3: overrun while holding 1234
    send_frame(16'h1234, 1'b0);
    check("t3_first_out", dout, 16'h1234);
    check("t3_first_ovr", ovr,  1'b0);
    send_frame(16'hFFFF, 1'b0);
    check("t3_out_kept", dout,  16'h1234);
    check("t3_ovr",      ovr,   1'b1);
    check("t3_valid",    valid, 1'b1);
    step(1'b0, 1'b0);
    check("t3_ovr_sticky", ovr, 1'b1);
    clr_ovr = 1'b1;
    step(1'b0, 1'b0);
    clr_ovr = 1'b0;
    check("t3_ovr_cleared", ovr,   1'b0);
    check("t3_valid_kept",  valid, 1'b1);
    consume();
    check("t3_consumed", valid, 1'b0);

    // 4: accept 00FF on the same cycle 8001 completes
    send_frame(16'h00FF, 1'b0);
    check("t4_first_out", dout, 16'h00FF);
    send_frame(16'h8001, 1'b1);
    check("t4_out",   dout,  16'h8001);
    check("t4_valid", valid, 1'b1);
    check("t4_ovr",   ovr,   1'b0);
    consume();
    check("t4_consumed", valid, 1'b0);

    // 5: 20 cycles of zeros under strobe stay idle
    busy_high_cnt = 0;
    valid_high_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      if (busy) busy_high_cnt++;
      if (valid) valid_high_cnt++;
    end
    en = 1'b0;
    check("t5_busy_cycles",  busy_high_cnt,  0);
    check("t5_valid_cycles", valid_high_cnt, 0);

    // 6: async reset after 7 data bits, with a valid word and overrun pending
    send_frame(16'h5A5A, 1'b0);
    send_frame(16'h0001, 1'b0);
    check("t6_pre_valid", valid, 1'b1);
    check("t6_pre_ovr",   ovr,   1'b1);
    w = 16'hC3C3;
    step(1'b1, 1'b1);
    for (int i = W - 1; i >= W - 7; i--) step(w[i], 1'b1);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_out",   dout,  16'h0000);
    check("t6_rst_valid", valid, 1'b0);
    check("t6_rst_busy",  busy,  1'b0);
    check("t6_rst_ovr",   ovr,   1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    check("t6_idle_after_rst", busy, 1'b0);
    send_frame(16'h0F0F, 1'b0);
    check("t6_out",   dout,  16'h0F0F);
    check("t6_valid", valid, 1'b1);
    check("t6_ovr",   ovr,   1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
